// File: rtl/key_debounce.sv
// Push-button debouncer: clean level plus one-cycle press/release pulses.
// Optional input synchronizer enabled with `define KEY_DEBOUNCE_SYNC_EN.
module key_debounce #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_in,
  output logic button_out,
  output logic button_posedge,
  output logic button_negedge
);

  localparam int DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end

  logic             s;
  logic [CNT_W-1:0] cnt;

`ifdef KEY_DEBOUNCE_SYNC_EN
  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], button_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];
`else
  assign s = button_in;
`endif

  // Any matching sample restarts the window; the counter
  // tops out at CNT_MAX, where the output takes the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      button_out     <= 1'b1;
      button_posedge <= 1'b0;
      button_negedge <= 1'b0;
    end else begin
      button_posedge <= 1'b0;
      button_negedge <= 1'b0;
      if (s == button_out) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt            <= '0;
        button_out     <= s;
        button_posedge <= s;
        button_negedge <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce at a scaled clock
// (10 kHz, so 1 ms = 10 cycles, window = 200 cycles).
module tb_key_debounce;

  localparam int CLK_HZ = 10000;
  localparam int DB_MS  = 20;
  localparam int SS     = 2;
  localparam int CPM    = CLK_HZ / 1000;
  localparam int DC     = CPM * DB_MS;
`ifdef KEY_DEBOUNCE_SYNC_EN
  localparam int LAT = DC + SS;
`else
  localparam int LAT = DC;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic button_in;
  logic button_out;
  logic button_posedge;
  logic button_negedge;

  key_debounce #(
    .CLK_FREQ_HZ(CLK_HZ),
    .DEBOUNCE_MS(DB_MS),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .button_in(button_in),
    .button_out(button_out),
    .button_posedge(button_posedge),
    .button_negedge(button_negedge)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int neg_cnt = 0;
  int pos_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (button_negedge) neg_cnt++;
    if (button_posedge) pos_cnt++;
    if (button_negedge && button_posedge) both_cnt++;
  end

  typedef struct {
    logic lvl;
    int   ms;
    logic out;
    int   neg;
    int   pos;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];

  task automatic chk(input string name, input int act,
                     input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  // Assumes we sit #1 after a rising edge.
  task automatic hold(input logic lvl, input int cyc);
    button_in = lvl;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Count edges until button_out reaches lvl, then check pulses.
  task automatic latency(input string name, input logic lvl);
    int n;
    n = 0;
    while (button_out != lvl && n < LAT + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_lat"}, n, LAT);
    chk({name, "_neg"}, int'(button_negedge), int'(!lvl));
    chk({name, "_pos"}, int'(button_posedge), int'(lvl));
    @(posedge clk);
    #1;
    chk({name, "_neg_1clk"}, int'(button_negedge), 0);
    chk({name, "_pos_1clk"}, int'(button_posedge), 0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1,   2, 1'b1, 0, 0};
    vecs[1]  = '{1'b0,   1, 1'b1, 0, 0};
    vecs[2]  = '{1'b1,   5, 1'b1, 0, 0};
    vecs[3]  = '{1'b0,   8, 1'b1, 0, 0};
    vecs[4]  = '{1'b1,  10, 1'b1, 0, 0};
    vecs[5]  = '{1'b0,  17, 1'b1, 0, 0};
    vecs[6]  = '{1'b1,  10, 1'b1, 0, 0};
    vecs[7]  = '{1'b0, 100, 1'b0, 1, 0};
    vecs[8]  = '{1'b1,  16, 1'b0, 0, 0};
    vecs[9]  = '{1'b0,   8, 1'b0, 0, 0};
    vecs[10] = '{1'b1, 200, 1'b1, 0, 1};

    rst_n = 1'b0;
    button_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_out", int'(button_out), 1);
    chk("rst_pulses", neg_cnt + pos_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      neg_cnt = 0;
      pos_cnt = 0;
      sb.push_back(vecs[i]);
      hold(vecs[i].lvl, vecs[i].ms * CPM);
      v = sb.pop_front();
      chk($sformatf("ph%0d_out", i), int'(button_out),
          int'(v.out));
      chk($sformatf("ph%0d_neg", i), neg_cnt, v.neg);
      chk($sformatf("ph%0d_pos", i), pos_cnt, v.pos);
    end

    button_in = 1'b0;
    latency("press", 1'b0);
    button_in = 1'b1;
    latency("release", 1'b1);

    neg_cnt = 0;
    pos_cnt = 0;
    hold(1'b0, 10 * CPM);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", int'(button_out), 1);
    chk("midrst_neg", int'(button_negedge), 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, LAT - 1);
    chk("midrst_hold", int'(button_out), 1);
    chk("midrst_noneg", neg_cnt, 0);
    @(posedge clk);
    #1;
    chk("midrst_fall", int'(button_out), 0);
    chk("midrst_negp", int'(button_negedge), 1);
    hold(1'b0, 20);
    chk("midrst_negcnt", neg_cnt, 1);
    chk("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
